// File: rtl/order_arbiter.sv
// order_arbiter: round-robin arbiter that merges one-entry order slots from NUM_REQ
// trading engines into a registered output. Define ORDER_RATE_LIMIT_EN for a token-bucket limiter.
module order_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int MAX_TOKENS    = 8,
   parameter int REFILL_PERIOD = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [64*NUM_REQ-1:0] req_order,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [63:0]           out_order,
   output logic [2:0]            out_port,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [15:0]           drop_count,
   output logic                  throttled
);
   localparam int IW = $clog2(NUM_REQ);

   logic [63:0]        slot [NUM_REQ];
   logic [NUM_REQ-1:0] pending;
   logic [IW-1:0]      last_grant;
   logic [IW-1:0]      grant_idx;
   logic               found;
   logic               free;
   logic               token_ok;
   logic               grant;
   logic [NUM_REQ-1:0] drop;
   logic [4:0]         drop_num;
   logic [16:0]        drop_sum;

   function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IW'(s);
   endfunction

   // Search begins just after the last winner, so the previous winner is considered last.
   always_comb begin
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (!found && pending[rr_index(last_grant, k)]) begin
            found     = 1'b1;
            grant_idx = rr_index(last_grant, k);
         end
      end
   end

   assign free  = !out_valid || out_ready;
   assign grant = free && enable && found && token_ok;

   // A strobe into a pending slot loses the older order unless that slot is leaving this cycle.
   always_comb begin
      drop     = '0;
      drop_num = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         drop[i]  = enable && req_valid[i] && pending[i] && !(grant && grant_idx == IW'(i));
         drop_num = drop_num + 5'(drop[i]);
      end
      drop_sum = {1'b0, drop_count} + 17'(drop_num);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REQ; i++) slot[i] <= '0;
         pending    <= '0;
         last_grant <= IW'(NUM_REQ - 1);
         out_order  <= '0;
         out_port   <= '0;
         out_valid  <= 1'b0;
         drop_count <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!enable) begin
               pending[i] <= 1'b0;
            end else if (req_valid[i]) begin
               slot[i]    <= req_order[64*i +: 64];
               pending[i] <= 1'b1;
            end else if (grant && grant_idx == IW'(i)) begin
               pending[i] <= 1'b0;
            end
         end
         drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         if (grant) begin
            out_order  <= slot[grant_idx];
            out_port   <= 3'(grant_idx);
            out_valid  <= 1'b1;
            last_grant <= grant_idx;
         end else if (free) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef ORDER_RATE_LIMIT_EN
   logic [7:0]  tokens;
   logic [15:0] refill_cnt;
   logic        refill;

   assign refill    = (refill_cnt == 16'(REFILL_PERIOD - 1));
   assign token_ok  = (tokens != 8'd0);
   assign throttled = free && enable && found && !token_ok;

   // A grant and a refill landing together cancel out.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tokens     <= 8'(MAX_TOKENS);
         refill_cnt <= '0;
      end else begin
         refill_cnt <= refill ? 16'd0 : refill_cnt + 16'd1;
         if (grant && !refill)
            tokens <= tokens - 8'd1;
         else if (refill && !grant && tokens != 8'(MAX_TOKENS))
            tokens <= tokens + 8'd1;
      end
   end
`else
   logic unused_cfg;
   assign token_ok   = 1'b1;
   assign throttled  = 1'b0;
   assign unused_cfg = (MAX_TOKENS != REFILL_PERIOD);
`endif

endmodule

// File: tb/tb_order_arbiter.sv
// Directed bench for order_arbiter: vector table for the main behaviours, hand sequences
// for drop-count saturation and (with ORDER_RATE_LIMIT_EN) the token bucket.
module tb_order_arbiter;
   localparam int NUM_REQ = 4;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic                  enable;
   logic [64*NUM_REQ-1:0] req_order;
   logic [NUM_REQ-1:0]    req_valid;
   logic [63:0]           out_order;
   logic [2:0]            out_port;
   logic                  out_valid;
   logic                  out_ready;
   logic [15:0]           drop_count;
   logic                  throttled;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        rst_n;
      logic        en;
      logic [3:0]  rv;
      logic [63:0] base;
      logic        rdy;
      logic        exp_v;
      logic        chk_data;
      logic [2:0]  exp_port;
      logic [63:0] exp_order;
      logic [15:0] exp_drops;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   order_arbiter #(.NUM_REQ(NUM_REQ), .MAX_TOKENS(8), .REFILL_PERIOD(16)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .enable    (enable),
      .req_order (req_order),
      .req_valid (req_valid),
      .out_order (out_order),
      .out_port  (out_port),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .drop_count(drop_count),
      .throttled (throttled)
   );

   function automatic vec_t row(input logic rst_n, input logic en, input logic [3:0] rv,
                                input logic [63:0] base, input logic rdy, input logic exp_v,
                                input logic chk_data, input logic [2:0] exp_port,
                                input logic [63:0] exp_order, input logic [15:0] exp_drops);
      vec_t v;
      v.rst_n = rst_n; v.en = en; v.rv = rv; v.base = base; v.rdy = rdy;
      v.exp_v = exp_v; v.chk_data = chk_data; v.exp_port = exp_port;
      v.exp_order = exp_order; v.exp_drops = exp_drops;
      return v;
   endfunction

   // Port i receives base+i; the edge is taken and outputs settle 1ns later.
   task automatic applyStimulus(input vec_t v);
      reset_n   = v.rst_n;
      enable    = v.en;
      req_valid = v.rv;
      out_ready = v.rdy;
      for (int i = 0; i < NUM_REQ; i++) req_order[64*i +: 64] = v.base + 64'(i);
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      reset_n   = 1'b0;
      enable    = 1'b1;
      req_valid = '0;
      req_order = '0;
      out_ready = 1'b1;

      // Single order from port 2
      vecs.push_back(row(0,1,4'b0000,64'h0,1, 0,1,0,64'h0,0));
      vecs.push_back(row(1,1,4'b0100,64'h01000ABC00000062,1, 0,0,0,64'h0,0));
      vecs.push_back(row(1,1,4'b0000,64'h0,1, 1,1,2,64'h01000ABC00000064,0));
      vecs.push_back(row(1,1,4'b0000,64'h0,1, 0,0,0,64'h0,0));
      // Overwrite on port 1 while the output is stalled
      vecs.push_back(row(0,1,4'b0000,64'h0,0, 0,1,0,64'h0,0));
      vecs.push_back(row(1,1,4'b0001,64'h10,0, 0,0,0,64'h0,0));
      vecs.push_back(row(1,1,4'b0010,64'hA0,0, 1,1,0,64'h10,0));
      vecs.push_back(row(1,1,4'b0010,64'hB0,0, 1,1,0,64'h10,1));
      vecs.push_back(row(1,1,4'b0000,64'h0,1, 1,1,1,64'hB1,1));
      vecs.push_back(row(1,1,4'b0000,64'h0,1, 0,0,0,64'h0,1));
      // Backpressure hold, then grant and new strobe on port 0 together
      vecs.push_back(row(0,1,4'b0000,64'h0,0, 0,1,0,64'h0,0));
      vecs.push_back(row(1,1,4'b0001,64'h30,0, 0,0,0,64'h0,0));
      vecs.push_back(row(1,1,4'b0000,64'h0,0, 1,1,0,64'h30,0));
      vecs.push_back(row(1,1,4'b0001,64'h40,0, 1,1,0,64'h30,0));
      for (int k = 0; k < 4; k++) vecs.push_back(row(1,1,4'b0000,64'h0,0, 1,1,0,64'h30,0));
      vecs.push_back(row(1,1,4'b0001,64'h50,1, 1,1,0,64'h40,0));
      vecs.push_back(row(1,1,4'b0000,64'h0,1, 1,1,0,64'h50,0));
      vecs.push_back(row(1,1,4'b0000,64'h0,1, 0,0,0,64'h0,0));
      // Enable dropped with three pending and the output occupied
      vecs.push_back(row(0,1,4'b0000,64'h0,0, 0,1,0,64'h0,0));
      vecs.push_back(row(1,1,4'b0001,64'h60,0, 0,0,0,64'h0,0));
      vecs.push_back(row(1,1,4'b1110,64'h70,0, 1,1,0,64'h60,0));
      vecs.push_back(row(1,0,4'b1110,64'h75,0, 1,1,0,64'h60,0));
      vecs.push_back(row(1,0,4'b0000,64'h0,1, 0,0,0,64'h0,0));
      vecs.push_back(row(1,0,4'b1111,64'h80,1, 0,0,0,64'h0,0));
      vecs.push_back(row(1,1,4'b0000,64'h0,1, 0,0,0,64'h0,0));
      vecs.push_back(row(1,1,4'b0100,64'h90,1, 0,0,0,64'h0,0));
      vecs.push_back(row(1,1,4'b0000,64'h0,1, 1,1,2,64'h92,0));
      // Reset mid-handshake, then round-robin fairness twice
      vecs.push_back(row(0,1,4'b0000,64'h0,0, 0,1,0,64'h0,0));
      vecs.push_back(row(1,1,4'b1111,64'h1000,1, 0,0,0,64'h0,0));
      for (int p = 0; p < 4; p++)
         vecs.push_back(row(1,1,4'b0000,64'h0,1, 1,1,3'(p),64'h1000 + 64'(p),0));
      vecs.push_back(row(1,1,4'b1111,64'h2000,1, 0,0,0,64'h0,0));
      for (int p = 0; p < 4; p++)
         vecs.push_back(row(1,1,4'b0000,64'h0,1, 1,1,3'(p),64'h2000 + 64'(p),0));
      vecs.push_back(row(1,1,4'b0000,64'h0,1, 0,0,0,64'h0,0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("row%0d_valid", i), 64'(out_valid), 64'(vecs[i].exp_v));
         checkOutput($sformatf("row%0d_drops", i), 64'(drop_count), 64'(vecs[i].exp_drops));
         checkOutput($sformatf("row%0d_throttled", i), 64'(throttled), 64'h0);
         if (vecs[i].chk_data) begin
            checkOutput($sformatf("row%0d_port", i), 64'(out_port), 64'(vecs[i].exp_port));
            checkOutput($sformatf("row%0d_order", i), out_order, vecs[i].exp_order);
         end
      end

      // Four overwrites per cycle drive drop_count into saturation
      applyStimulus(row(0,1,4'b0000,64'h0,0, 0,0,0,64'h0,0));
      applyStimulus(row(1,1,4'b0001,64'h100,0, 0,0,0,64'h0,0));
      applyStimulus(row(1,1,4'b1111,64'h200,0, 0,0,0,64'h0,0));
      checkOutput("sat_start_drops", 64'(drop_count), 64'h0);
      checkOutput("sat_start_valid", 64'(out_valid), 64'h1);
      for (int k = 0; k < 16383; k++) applyStimulus(row(1,1,4'b1111,64'h300,0, 0,0,0,64'h0,0));
      checkOutput("sat_near_drops", 64'(drop_count), 64'hFFFC);
      applyStimulus(row(1,1,4'b1111,64'h300,0, 0,0,0,64'h0,0));
      checkOutput("sat_hit_drops", 64'(drop_count), 64'hFFFF);
      for (int k = 0; k < 1116; k++) applyStimulus(row(1,1,4'b1111,64'h300,0, 0,0,0,64'h0,0));
      checkOutput("sat_hold_drops", 64'(drop_count), 64'hFFFF);
      checkOutput("sat_hold_order", out_order, 64'h100);

`ifdef ORDER_RATE_LIMIT_EN
      begin
         int early_grants;
         int late_grants;
         int late_first;
         int late_second;
         early_grants = 0;
         late_grants  = 0;
         late_first   = 0;
         late_second  = 0;
         applyStimulus(row(0,1,4'b0000,64'h0,1, 0,0,0,64'h0,0));
         for (int e = 1; e <= 44; e++) begin
            applyStimulus(row(1,1,(e <= 20) ? 4'b0001 : 4'b0000,64'h5000 + 64'(e),1, 0,0,0,64'h0,0));
            if (out_valid) begin
               if (e <= 15) begin
                  early_grants++;
               end else begin
                  late_grants++;
                  if (late_grants == 1) late_first = e;
                  if (late_grants == 2) late_second = e;
               end
            end
            if (e == 12) checkOutput("rate_throttled", 64'(throttled), 64'h1);
         end
         checkOutput("rate_burst_grants", 64'(early_grants), 64'd8);
         checkOutput("rate_late_grants", 64'(late_grants), 64'd2);
         checkOutput("rate_first_refill_edge", 64'(late_first), 64'd17);
         checkOutput("rate_second_refill_edge", 64'(late_second), 64'd33);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
